// File: rtl/ultrasonido_pkg.sv
// Shared types and constants for the ultrasonic range controller.
package ultrasonido_pkg;
    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_LOW,
        WAIT_HIGH,
        MEASURE,
        DONE
    } state_t;

    localparam int TRIG_TICKS_DEF    = 1;
    localparam int TIMEOUT_TICKS_DEF = 3000;
    // 0.172 cm per 10 us tick approximated as 11/64
    localparam int CM_MUL   = 11;
    localparam int CM_SHIFT = 6;
endpackage

// File: rtl/ultrasonido_sync.sv
// Two-flop synchronizer for an asynchronous level, plus a third stage for edge detection.
// Synchronized level appears 2 cycles after the input; edges are reported in that same cycle.
module ultrasonido_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sh_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= {sh_q[1:0], async_i};
        end
    end

    assign sync_o = sh_q[1];
    assign rise_o = sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/ultrasonido_ctrl.sv
// Ultrasonic sensor controller: trigger pulse, echo width measured in ticks, timeout handling.
// Define ULTRASONIDO_CM_EN to report centimetres (one extra register stage, valid one cycle later).
module ultrasonido_ctrl
    import ultrasonido_pkg::*;
#(
    parameter int TRIG_TICKS    = TRIG_TICKS_DEF,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
    parameter int CW            = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          start,
    input  logic          echo,
    output logic          trigger,
    output logic [CW-1:0] distance,
    output logic          valid,
    output logic          busy,
    output logic          timeout
);
    localparam logic [CW-1:0] TRIG_C = CW'(TRIG_TICKS);
    localparam logic [CW-1:0] TO_C   = CW'(TIMEOUT_TICKS);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc, dist_q;
    logic          to_q, to_d;
    logic          hit_to;
    logic          echo_s, echo_rise, echo_fall;

    ultrasonido_sync u_echo_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(echo),
        .sync_o (echo_s),
        .rise_o (echo_rise),
        .fall_o (echo_fall)
    );

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    assign hit_to  = tick && (cnt_inc >= TO_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end
            end
            TRIG: begin
                if (tick) begin
                    if (cnt_inc >= TRIG_C) begin
                        state_d = WAIT_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            WAIT_LOW: begin
                if (hit_to) begin
                    state_d = DONE;
                    cnt_d   = '1;
                    to_d    = 1'b1;
                end else begin
                    if (tick) cnt_d = cnt_inc;
                    // echo left over from an earlier ping must drop before we arm
                    if (!echo_s) state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (echo_rise) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                end else if (hit_to) begin
                    state_d = DONE;
                    cnt_d   = '1;
                    to_d    = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    state_d = DONE;
                    cnt_d   = tick ? cnt_inc : cnt_q;
                end else if (hit_to) begin
                    state_d = DONE;
                    cnt_d   = '1;
                    to_d    = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ULTRASONIDO_CM_EN
    logic [CW+3:0] prod;
    logic          valid_q;

    assign prod = {4'b0000, cnt_q} * (CW+4)'(CM_MUL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dist_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == DONE);
            if (state_q == DONE) dist_q <= to_q ? '1 : CW'(prod >> CM_SHIFT);
        end
    end

    assign valid = valid_q;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dist_q <= '0;
        end else if (state_d == DONE && state_q != DONE) begin
            dist_q <= cnt_d;
        end
    end

    assign valid = (state_q == DONE);
`endif

    assign distance = dist_q;
    assign trigger  = (state_q == TRIG);
    assign busy     = (state_q != IDLE);
    assign timeout  = to_q;
endmodule

// File: tb/tb_ultrasonido_ctrl.sv
// Directed bench for ultrasonido_ctrl: measurement, timeout, stale echo, ignored starts, reset abort.
module tb_ultrasonido_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, tick, start, echo;
    logic        trigger, valid, busy, timeout;
    logic [15:0] distance;
    int          total = 0;
    int          passed = 0;
    int          vcount = 0;
    int          vbase;
    bit          got;

    always #5 clk = ~clk;

    ultrasonido_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .start   (start),
        .echo    (echo),
        .trigger (trigger),
        .distance(distance),
        .valid   (valid),
        .busy    (busy),
        .timeout (timeout)
    );

    always @(negedge clk) if (valid === 1'b1) vcount++;

    function automatic logic [15:0] exp_dist(input int raw);
`ifdef ULTRASONIDO_CM_EN
        return 16'((raw * 11) >> 6);
`else
        return 16'(raw);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_meas();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_tick();
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; echo = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trigger", trigger, 0);
        chk("rst_distance", distance, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic 100-tick echo
        vbase = vcount;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("trig_high", trigger, 1);
        do_tick();
        chk("trig_low_after_tick", trigger, 0);
        echo = 1'b1;
        repeat (4) @(negedge clk);
        repeat (100) do_tick();
        echo = 1'b0;
        wait_valid(20, got);
        chk("m100_valid_seen", got, 1);
        chk("m100_distance", distance, exp_dist(100));
        chk("m100_timeout", timeout, 0);
        @(negedge clk);
        chk("m100_valid_one_cycle", valid, 0);
        repeat (3) @(negedge clk);
        chk("m100_valid_count", vcount - vbase, 1);
        chk("m100_idle", busy, 0);

        // echo never rises
        vbase = vcount;
        start_meas();
        repeat (2999) do_tick();
        chk("to_busy_before", busy, 1);
        chk("to_no_valid_before", vcount - vbase, 0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_valid(10, got);
        chk("to_valid_seen", got, 1);
        chk("to_distance", distance, 16'hFFFF);
        chk("to_flag", timeout, 1);
        repeat (3) @(negedge clk);

        // stale echo held high across the start
        echo = 1'b1;
        repeat (4) @(negedge clk);
        vbase = vcount;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("stale_timeout_cleared", timeout, 0);
        do_tick();
        repeat (5) do_tick();
        chk("stale_busy", busy, 1);
        chk("stale_no_valid", vcount - vbase, 0);
        echo = 1'b0;
        repeat (4) @(negedge clk);
        echo = 1'b1;
        repeat (4) @(negedge clk);
        repeat (20) do_tick();
        echo = 1'b0;
        wait_valid(20, got);
        chk("stale_valid_seen", got, 1);
        chk("stale_distance", distance, exp_dist(20));
        repeat (3) @(negedge clk);

        // start pulses during MEASURE are ignored
        vbase = vcount;
        start_meas();
        echo = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            do_tick();
            if (i % 10 == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        echo = 1'b0;
        wait_valid(20, got);
        chk("ign_valid_seen", got, 1);
        chk("ign_distance", distance, exp_dist(30));
        repeat (6) @(negedge clk);
        chk("ign_valid_count", vcount - vbase, 1);
        chk("ign_no_restart", busy, 0);
        chk("ign_distance_hold", distance, exp_dist(30));

        // tick coincident with synchronized echo fall at count 9
        start_meas();
        echo = 1'b1;
        repeat (4) @(negedge clk);
        repeat (9) do_tick();
        echo = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        wait_valid(10, got);
        chk("coinc_valid_seen", got, 1);
        chk("coinc_distance", distance, exp_dist(10));
        repeat (3) @(negedge clk);

        // reset during MEASURE at tick 50
        vbase = vcount;
        start_meas();
        echo = 1'b1;
        repeat (4) @(negedge clk);
        repeat (50) do_tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_trigger", trigger, 0);
        chk("abort_distance", distance, 0);
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_timeout", timeout, 0);
        echo = 1'b0;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_valid", vcount - vbase, 0);
        chk("abort_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
